// File: rtl/mux2_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : mux2_rr_arb
// Brief    : Two-channel round-robin valid/ready arbiter with per-grant burst
//            hold, driving a 2:1 mux select and a one-entry output register.
// Revision : 1.0 - initial release
// ============================================================================
module mux2_rr_arb #(
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_vld0,
    input  logic [DW-1:0] i_dat0,
    output logic          o_rdy0,
    input  logic          i_vld1,
    input  logic [DW-1:0] i_dat1,
    output logic          o_rdy1,
    output logic          o_sel,
    output logic          o_vld,
    output logic [DW-1:0] o_dat,
    input  logic          i_rdy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] C_LAST = 4'(BURST - 1);

    state_t          r_state;
    logic            r_prio;
    logic [3:0]      r_cnt;
    logic            r_sel;
    logic            r_vld;
    logic [DW-1:0]   r_dat;

    state_t          w_state_nxt;
    logic            w_prio_nxt;
    logic [3:0]      w_cnt_nxt;
    logic            w_sel_nxt;

    logic            w_load_en;
    logic            w_xfer0;
    logic            w_xfer1;
    logic            w_own_vld;
    logic            w_own_xfer;

    // The output slot can take a new beat when empty or draining this cycle.
    assign w_load_en  = !r_vld || i_rdy;
    assign o_rdy0     = (r_state == ST_OWN0) && w_load_en;
    assign o_rdy1     = (r_state == ST_OWN1) && w_load_en;
    assign w_xfer0    = i_vld0 && o_rdy0;
    assign w_xfer1    = i_vld1 && o_rdy1;
    assign w_own_vld  = (r_state == ST_OWN0) ? i_vld0 : i_vld1;
    assign w_own_xfer = w_xfer0 || w_xfer1;

    assign o_sel = r_sel;
    assign o_vld = r_vld;
    assign o_dat = r_dat;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_cnt   <= 4'd0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE: begin
                // Channel 0 wins when alone or when it holds priority.
                if (i_vld0 && (!i_vld1 || !r_prio)) begin
                    w_state_nxt = ST_OWN0;
                    w_sel_nxt   = 1'b0;
                    w_prio_nxt  = 1'b1;
                    w_cnt_nxt   = 4'd0;
                end else if (i_vld1) begin
                    w_state_nxt = ST_OWN1;
                    w_sel_nxt   = 1'b1;
                    w_prio_nxt  = 1'b0;
                    w_cnt_nxt   = 4'd0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!w_own_vld) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (w_own_xfer) begin
                    if (r_cnt == C_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (w_xfer0) begin
            r_vld <= 1'b1;
            r_dat <= i_dat0;
        end else if (w_xfer1) begin
            r_vld <= 1'b1;
            r_dat <= i_dat1;
        end else if (i_rdy) begin
            r_vld <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/mux2_rr_arb.md
# mux2_rr_arb

Two-channel round-robin stream arbiter that sits directly upstream of the 2:1 mux stage. It decides which of two valid/ready sources owns the datapath and drives that mux's select input from its registered grant. It also registers the winning beat into a single-entry output stage with downstream backpressure. Each grant is held for up to BURST beats, so packets of up to BURST beats from one source are not interleaved.

## Interface
Parameters:
- DW, 8, data width of each channel and of the output
- BURST, 4, maximum consecutive beats per grant; legal range 1..15

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst  input  1  synchronous, active-high reset
- i_vld0  input  1  channel 0 beat valid
- i_dat0  input  DW  channel 0 data
- o_rdy0  output  1  channel 0 ready; a transfer occurs when i_vld0 && o_rdy0
- i_vld1  input  1  channel 1 beat valid
- i_dat1  input  DW  channel 1 data
- o_rdy1  output  1  channel 1 ready
- o_sel  output  1  current or last owner (0/1); drives the mux2 select, i.e. the mux's i_sel input
- o_vld  output  1  output register holds a beat
- o_dat  output  DW  output register data
- i_rdy  input  1  downstream ready; the output transfer occurs when o_vld && i_rdy

## Operation
- Internal registers:
  - state: IDLE, OWN0, OWN1
  - prio pointer (1 bit): the preferred channel
  - beat counter cnt (4 bits)
  - o_sel, o_vld, o_dat
- load_en = !o_vld || i_rdy. This is combinational and gives a one-entry pipeline with full throughput.
- o_rdyN = (state==OWNN) && load_en. Both readies are 0 in IDLE, and they are never 1 simultaneously.
- IDLE:
  - No beat is accepted.
  - Only one i_vldN high: go to OWNN.
  - Both high: go to OWN[prio].
  - Neither high: stay in IDLE.
  - On a grant to k: o_sel<=k, prio<=!k, cnt<=0.
- OWNk, checked in this priority order:
  1. i_vldk==0: go to IDLE, cnt<=0.
  2. A transfer on k with cnt==BURST-1: go to IDLE, cnt<=0.
  3. A transfer on k otherwise: cnt<=cnt+1 and stay in OWNk.
  4. No transfer (stalled): hold.
- Output register:
  - Transfer on channel k: o_dat<=i_datk, o_vld<=1.
  - Otherwise, if i_rdy: o_vld<=0, and o_dat holds its last value.
  - While o_vld && !i_rdy, o_vld and o_dat are held.
- o_sel is only updated on a grant. It keeps the last owner through IDLE.
- BURST==1: every beat is followed by IDLE, which gives strict per-beat alternation under contention.

## Timing
- Reset (i_rst high at an edge) gives:
  - state=IDLE, prio=0, cnt=0
  - o_sel=0, o_vld=0, o_dat=0
  - o_rdy0=o_rdy1=0 (combinational result of IDLE)
- Reset mid-burst: the in-flight o_vld beat is dropped, and no partial count survives.
- Grant latency: 1 cycle from a valid in IDLE to ready high (the IDLE cycle itself accepts nothing).
- Data latency: a beat accepted at edge n is on o_dat with o_vld=1 after edge n.
- Throughput: 1 beat per cycle within a grant, and 1 bubble cycle per grant change.
  - Sustained contention with BURST=4 gives 4 beats then 1 IDLE, alternating channels: 80% utilisation.
- Backpressure: i_rdy=0 with o_vld=1 forces o_rdyN=0 in the same cycle. cnt does not advance.
- Simultaneous i_rdy=1 and a new transfer: the old beat leaves and the new beat loads on the same edge, with no bubble.
- An owner dropping valid mid-burst releases the grant after that cycle. The next grant then favours the other channel, per prio.

## Test plan
- **Reset:** hold i_rst 2 cycles with both valids high -> o_vld=0, o_sel=0, o_rdy0=o_rdy1=0 throughout; first grant goes to channel 0 (prio=0) one cycle after release.
- **Single source:** BURST=4, ch0 streams 0x10..0x17 continuously, i_rdy=1 -> o_dat emits 0x10..0x13, then one bubble, then 0x14..0x17; o_sel=0 throughout; o_rdy1 never high.
- **Contention:** both streaming (ch0 0xA0.., ch1 0xB0..), BURST=4 -> output A0-A3, bubble, B0-B3, bubble, A4-A7; o_sel toggles 0,1,0 on the grant edges.
- **Backpressure:** mid-burst, drop i_rdy for 3 cycles -> o_dat is stable and o_rdyN=0 during the stall, no beat is lost or duplicated, and cnt resumes, so the burst still totals 4.
- **Early release:** ch1 owns the grant, sends 2 beats then drops i_vld1 while ch0 is valid -> IDLE for 1 cycle, then OWN0; o_sel goes to 0; ch0 gets a full 4-beat burst.
- **BURST=1 and reset mid-burst:** with BURST=1 under contention, beats alternate 0,1,0,1 with a bubble between each. Separately, assert i_rst while o_vld=1 and i_rdy=0 -> the next cycle shows o_vld=0 and state IDLE.
